timer_device: RTL and testbench

TIMER_DEVICE -- requirements
Module: timer_device

---
 rtl/timer_pkg.sv | 36 +++
 rtl/timer_prescaler.sv | 45 ++++
 rtl/timer_device.sv | 123 ++++++++++++
 tb/tb_timer_device.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg
// Shared definitions for the memory-mapped machine timer: word indices of the
// register map (byte address bits [4:2]), CTRL field positions and the reset
// values of the architectural state. Also provides a helper that packs the
// CTRL fields into a read word.
package timer_pkg;

  // Register word indices (byte offset >> 2)
  localparam logic [2:0] REG_MTIME_LO    = 3'd0;  // 0x00
  localparam logic [2:0] REG_MTIME_HI    = 3'd1;  // 0x04
  localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;  // 0x08
  localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;  // 0x0C
  localparam logic [2:0] REG_CTRL        = 3'd4;  // 0x10
  localparam logic [2:0] REG_STATUS      = 3'd5;  // 0x14

  // CTRL field positions
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_PRESC_LSB   = 8;
  localparam int CTRL_PRESC_WIDTH = 8;

  // Reset values
  localparam logic [63:0] MTIME_RST    = 64'h0;
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic        CTRL_EN_RST  = 1'b0;
  localparam logic [7:0]  CTRL_PRESC_RST = 8'h00;

  // CTRL read word: only EN and PRESCALE are implemented, other bits read 0.
  function automatic logic [31:0] ctrl_word(input logic en, input logic [7:0] presc);
    logic [31:0] w;
    w = 32'h0;
    w[CTRL_EN_BIT] = en;
    w[CTRL_PRESC_LSB +: CTRL_PRESC_WIDTH] = presc;
    return w;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler
// 8-bit prescaler for the machine timer. While enabled it counts up; when the
// count equals prescale_i it returns to zero and tick_o is high for that cycle,
// so the tick period is prescale_i+1 enabled cycles (prescale_i=0 ticks every
// enabled cycle). Disabling freezes the count. clear_i forces the count to
// zero and suppresses the tick in that cycle.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   en_i        count enable
//   prescale_i  terminal count
//   clear_i     restart the count from zero
//   tick_o      one-cycle tick (combinational from the current count)
module timer_prescaler (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [7:0] prescale_i,
  input  logic       clear_i,
  output logic       tick_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick_o = en_i && !clear_i && (cnt_q == prescale_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 8'h00;
    end else if (en_i) begin
      cnt_d = tick_o ? 8'h00 : cnt_q + 8'h01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_device.sv
// timer_device
// Memory-mapped 64-bit machine timer (mtime / mtimecmp) with a level interrupt.
// Register map (byte offsets, addr bits [4:2] decoded):
//   0x00 MTIME_LO  0x04 MTIME_HI  0x08 MTIMECMP_LO  0x0C MTIMECMP_HI
//   0x10 CTRL (bit0 EN, bits[15:8] PRESCALE)  0x14 STATUS (bit0 irq, RO)
//   0x18/0x1C read 0, writes ignored.
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   device_req_i    one-cycle access request
//   device_addr_i   byte address
//   device_we_i     1 = write, 0 = read
//   device_wdata_i  write data
//   device_rdata_o  registered read data (valid the cycle after a read, held)
//   timer_irq_o     registered (mtime >= mtimecmp)
module timer_device
  import timer_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    device_req_i,
  input  logic [AddressWidth-1:0] device_addr_i,
  input  logic                    device_we_i,
  input  logic [DataWidth-1:0]    device_wdata_i,
  output logic [DataWidth-1:0]    device_rdata_o,
  output logic                    timer_irq_o
);

  logic [63:0]          mtime_q, mtime_d;
  logic [63:0]          mtimecmp_q, mtimecmp_d;
  logic                 ctrl_en_q, ctrl_en_d;
  logic [7:0]           ctrl_presc_q, ctrl_presc_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 irq_q, irq_d;

  logic       wr, rd, wr_ctrl, tick;
  logic [2:0] idx;
  logic [31:0] wdata;

  // Only the word index is decoded; the remaining address bits are don't-care.
  logic unused_addr;
  assign unused_addr = ^{device_addr_i[AddressWidth-1:5], device_addr_i[1:0]};

  assign idx     = device_addr_i[4:2];
  assign wdata   = device_wdata_i[31:0];
  assign wr      = device_req_i && device_we_i;
  assign rd      = device_req_i && !device_we_i;
  assign wr_ctrl = wr && (idx == REG_CTRL);

  timer_prescaler u_prescaler (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (ctrl_en_q),
    .prescale_i (ctrl_presc_q),
    .clear_i    (wr_ctrl),
    .tick_o     (tick)
  );

  always_comb begin
    mtime_d      = mtime_q;
    mtimecmp_d   = mtimecmp_q;
    ctrl_en_d    = ctrl_en_q;
    ctrl_presc_d = ctrl_presc_q;
    rdata_d      = rdata_q;
    // Compare uses pre-edge state so irq lags the condition by one cycle.
    irq_d        = (mtime_q >= mtimecmp_q);

    // A software write to either mtime half takes priority over the tick,
    // and the whole 64-bit counter skips its increment that cycle.
    if (wr && idx == REG_MTIME_LO) begin
      mtime_d[31:0] = wdata;
    end else if (wr && idx == REG_MTIME_HI) begin
      mtime_d[63:32] = wdata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr && idx == REG_MTIMECMP_LO) mtimecmp_d[31:0]  = wdata;
    if (wr && idx == REG_MTIMECMP_HI) mtimecmp_d[63:32] = wdata;
    if (wr_ctrl) begin
      ctrl_en_d    = wdata[CTRL_EN_BIT];
      ctrl_presc_d = wdata[CTRL_PRESC_LSB +: CTRL_PRESC_WIDTH];
    end

    if (rd) begin
      rdata_d = '0;
      case (idx)
        REG_MTIME_LO:    rdata_d[31:0] = mtime_q[31:0];
        REG_MTIME_HI:    rdata_d[31:0] = mtime_q[63:32];
        REG_MTIMECMP_LO: rdata_d[31:0] = mtimecmp_q[31:0];
        REG_MTIMECMP_HI: rdata_d[31:0] = mtimecmp_q[63:32];
        REG_CTRL:        rdata_d[31:0] = ctrl_word(ctrl_en_q, ctrl_presc_q);
        REG_STATUS:      rdata_d[0]    = irq_q;
        default:         rdata_d       = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q      <= MTIME_RST;
      mtimecmp_q   <= MTIMECMP_RST;
      ctrl_en_q    <= CTRL_EN_RST;
      ctrl_presc_q <= CTRL_PRESC_RST;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      ctrl_en_q    <= ctrl_en_d;
      ctrl_presc_q <= ctrl_presc_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
    end
  end

  assign device_rdata_o = rdata_q;
  assign timer_irq_o    = irq_q;

endmodule

// File: tb/tb_timer_device.sv
// tb_timer_device
// Drives directed and random bus traffic into timer_device. For every clock
// edge the driver advances a behavioural model of the timer and pushes the
// expected (irq, rdata) seen after that edge into a queue; an independent
// monitor pops one entry per edge and compares it with the DUT outputs.
module tb_timer_device;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        irq;
    logic [31:0] rdata;
    string       what;
  } exp_t;
  exp_t exp_q[$];

  // Behavioural model state
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_en;
  logic [7:0]  m_presc;
  int          m_wait;   // enabled cycles elapsed in the current tick period
  logic        m_irq;
  logic [31:0] m_rdata;

  timer_device #(.DataWidth(32), .AddressWidth(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .device_req_i   (req),
    .device_addr_i  (addr),
    .device_we_i    (we),
    .device_wdata_i (wdata),
    .device_rdata_o (rdata),
    .timer_irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus cycle: drive at the falling edge, predict the next rising edge.
  task automatic cycle(input logic r, input logic rq, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    int   word;
    logic tick_now;
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; we = w; addr = a; wdata = d;
    word = int'(a[4:2]);
    if (r) begin
      m_mtime = 64'h0; m_cmp = '1; m_en = 1'b0; m_presc = 8'h0;
      m_wait = 0; m_irq = 1'b0; m_rdata = 32'h0;
    end else begin
      if (rq && !w) begin
        case (word)
          0: m_rdata = m_mtime[31:0];
          1: m_rdata = m_mtime[63:32];
          2: m_rdata = m_cmp[31:0];
          3: m_rdata = m_cmp[63:32];
          4: m_rdata = {16'h0, m_presc, 7'h0, m_en};
          5: m_rdata = {31'h0, m_irq};
          default: m_rdata = 32'h0;
        endcase
        $display("t=%0t RD addr=%08h", $time, a);
      end else if (rq) begin
        $display("t=%0t WR addr=%08h data=%08h", $time, a, d);
      end
      m_irq = (m_mtime >= m_cmp);
      // Tick once every (PRESCALE+1) enabled cycles; a CTRL write restarts the period.
      tick_now = 1'b0;
      if (rq && w && word == 4) begin
        m_wait = 0;
      end else if (m_en) begin
        if (m_wait == int'(m_presc)) begin
          tick_now = 1'b1;
          m_wait = 0;
        end else begin
          m_wait++;
        end
      end
      if (rq && w && word == 0)      m_mtime[31:0]  = d;
      else if (rq && w && word == 1) m_mtime[63:32] = d;
      else if (tick_now)             m_mtime = m_mtime + 1;
      if (rq && w && word == 2) m_cmp[31:0]  = d;
      if (rq && w && word == 3) m_cmp[63:32] = d;
      if (rq && w && word == 4) begin
        m_en = d[0];
        m_presc = d[15:8];
      end
    end
    e.irq = m_irq;
    e.rdata = m_rdata;
    e.what = (rq && !w && !r) ? "read" : "hold";
    exp_q.push_back(e);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd_reg(input logic [31:0] a);
    cycle(1'b0, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Monitor: one expectation per rising edge, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (irq !== e.irq) begin
          errors++;
          $display("FAIL irq t=%0t got=%0b exp=%0b", $time, irq, e.irq);
        end
        checks++;
        if (rdata !== e.rdata) begin
          errors++;
          $display("FAIL rdata_%s t=%0t got=%08h exp=%08h", e.what, $time, rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int sel;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;

    // Reset and read-back
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    rd_reg(32'h08); rd_reg(32'h0C); rd_reg(32'h10); rd_reg(32'h14);
    rd_reg(32'h18); idle();

    // Counting and compare
    wr_reg(32'h08, 32'd5);
    wr_reg(32'h0C, 32'd0);
    wr_reg(32'h10, 32'h0000_0001);
    repeat (8) rd_reg(32'h00);
    rd_reg(32'h14); idle();

    // Prescaler, then freeze
    wr_reg(32'h10, 32'h0000_0301);
    repeat (12) rd_reg(32'h00);
    wr_reg(32'h10, 32'h0000_0300);
    repeat (4) rd_reg(32'h00);

    // Carry and wrap
    wr_reg(32'h08, 32'hFFFF_FFFF);
    wr_reg(32'h0C, 32'hFFFF_FFFF);
    wr_reg(32'h04, 32'hFFFF_FFFF);
    wr_reg(32'h00, 32'hFFFF_FFFE);
    wr_reg(32'h10, 32'h0000_0001);
    repeat (2) begin rd_reg(32'h00); rd_reg(32'h04); end
    rd_reg(32'h14); idle(); idle();

    // Collision: MTIME_LO write on a tick cycle (PRESCALE=0 ticks every cycle)
    wr_reg(32'h00, 32'h0000_0100);
    rd_reg(32'h00); rd_reg(32'h00);

    // Reset during a write, then first access right after reset
    cycle(1'b1, 1'b1, 1'b1, 32'h08, 32'h1234_5678);
    rd_reg(32'h08);
    rd_reg(32'h00);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 99));
      a = {$urandom_range(0, 7) == 0 ? $urandom() : 32'h0};
      a[4:2] = 3'($urandom_range(0, 7));
      a[1:0] = 2'($urandom_range(0, 3));
      case (a[4:2])
        3'd1, 3'd3: d = ($urandom_range(0, 3) == 0) ? $urandom() : 32'h0;
        3'd4: begin
          d = $urandom();
          d[15:8] = 8'($urandom_range(0, 3));
          if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
        end
        default: d = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 80));
      endcase
      if (sel < 2)        cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, a, d);
      else if (sel < 20)  idle();
      else if (sel < 45)  wr_reg(a, d);
      else                rd_reg(a);
    end

    // Drain the scoreboard (bounded)
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
